uart_rx_ctrl: RTL

//  Front-end controller for the 16x-oversampling UART receiver. Synchronises the raw rx pin,

---
 rtl/uart_rx_ctrl_if.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Host-side bus of the UART receive front-end: divisor programming, frame status,
// FWFT byte FIFO read port, sticky overrun and idle timeout.
//   master : host logic (drives dvsr_in/dvsr_wr/rd/ovr_clr)
//   slave  : uart_rx_ctrl (drives busy/rd_data/rd_valid/overrun/timeout)
interface uart_rx_ctrl_if #(
    parameter int unsigned DVSR_W = 11
);
    logic [DVSR_W-1:0] dvsr_in;
    logic              dvsr_wr;
    logic              busy;
    logic              rd;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              overrun;
    logic              ovr_clr;
    logic              timeout;

    modport master (
        output dvsr_in, dvsr_wr, rd, ovr_clr,
        input  busy, rd_data, rd_valid, overrun, timeout
    );

    modport slave (
        input  dvsr_in, dvsr_wr, rd, ovr_clr,
        output busy, rd_data, rd_valid, overrun, timeout
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Front-end controller for a 16x-oversampling UART receiver.
// Synchronises rx_pin, generates the s_tick oversample strobe from a programmable
// divisor (applied only between frames), tracks frame activity and buffers received
// bytes in a first-word-fall-through FIFO with a sticky overrun flag.
// Optional feature macro: RX_TIMEOUT_EN (idle timeout counter on host.timeout).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   rx_pin         : raw asynchronous serial line
//   rx_sync        : synchronised line to the receiver
//   s_tick         : one-clk oversample strobe to the receiver
//   rx_done_tick   : receiver byte-complete pulse, rx_dout valid with it
//   host           : host bus (uart_rx_ctrl_if.slave)
module uart_rx_ctrl #(
    parameter int unsigned DVSR_W        = 11,
    parameter int unsigned DVSR_RST      = 326,
    parameter int unsigned FIFO_AW       = 2,
    parameter int unsigned TIMEOUT_TICKS = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    output logic       rx_sync,
    output logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    uart_rx_ctrl_if.slave host
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              sync_q1, sync_q2;
    logic [DVSR_W-1:0] dvsr_reg;
    logic [DVSR_W-1:0] dvsr_pend;
    logic              pend;
    logic [DVSR_W-1:0] tick_cnt;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    logic               ovr_q;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= rx_pin;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_sync = sync_q2;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: a start bit beats a pending divisor so the divisor never changes mid-frame
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!sync_q2)  state_nxt = ST_FRAME;
                else if (pend) state_nxt = ST_RELOAD;
            end
            ST_FRAME: begin
                if (rx_done_tick) state_nxt = ST_IDLE;
            end
            ST_RELOAD: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign host.busy = (state != ST_IDLE);

    // Pending divisor; a write in the reload cycle survives as the next pending value
    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= 1'b0;
            dvsr_pend <= '0;
        end else if (host.dvsr_wr) begin
            pend      <= 1'b1;
            dvsr_pend <= host.dvsr_in;
        end else if (state == ST_RELOAD) begin
            pend      <= 1'b0;
        end
    end

    // Oversample counter: 0..dvsr_reg, restarted from 0 when a new divisor is applied
    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_reg <= DVSR_W'(DVSR_RST);
            tick_cnt <= '0;
        end else if (state == ST_RELOAD) begin
            dvsr_reg <= dvsr_pend;
            tick_cnt <= '0;
        end else if (tick_cnt == dvsr_reg) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DVSR_W'(1);
        end
    end

    assign s_tick = (tick_cnt == dvsr_reg) && (state != ST_RELOAD);

    // FIFO control: a full FIFO still accepts a byte when the host pops in the same cycle
    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = host.rd && !fifo_empty;
    assign push       = rx_done_tick && (!fifo_full || host.rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rx_dout;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign host.rd_data  = mem[rd_ptr];
    assign host.rd_valid = !fifo_empty;

    // Sticky overrun; a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (reset)                                         ovr_q <= 1'b0;
        else if (rx_done_tick && fifo_full && !host.rd)    ovr_q <= 1'b1;
        else if (host.ovr_clr)                             ovr_q <= 1'b0;
    end

    assign host.overrun = ovr_q;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [TO_W-1:0] to_cnt;

    // Idle timeout: counts s_ticks while unread data waits and the line is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (push || pop || (state == ST_IDLE && state_nxt == ST_FRAME)) begin
            to_cnt <= '0;
        end else if (s_tick && state == ST_IDLE && !fifo_empty &&
                     to_cnt != TO_W'(TIMEOUT_TICKS)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign host.timeout = (to_cnt == TO_W'(TIMEOUT_TICKS));
`else
    assign host.timeout = 1'b0;
`endif

endmodule
